// File: rtl/ami_types_pkg.sv
// AMITypes: shared AMI memory-path types, widths and TLB entry/state definitions.
package AMITypes;
    localparam int AMI_APP_BITS            = 4;
    localparam int AMI_PORT_BITS           = 2;
    localparam int AMI_CHANNEL_BITS        = 1;
    localparam int AMI_NUM_APP_TLB_ENTRIES = 4;
    localparam int AMI_DATA_BITS           = 64;
    localparam int AMI_SIZE_BITS           = 8;
    localparam bit DISABLE_INTERLEAVE      = 1'b0;

    typedef enum logic [1:0] {
        APP_TLB_DISABLED,
        APP_TLB_PROGRAMMING,
        APP_TLB_ENABLED
    } APP_TLB_STATE;

    typedef enum logic [1:0] {
        XLAT_MISS,
        XLAT_PERM,
        XLAT_NOT_RESIDENT
    } XLAT_CAUSE;

    typedef struct packed {
        logic                     valid;
        logic                     isWrite;
        logic [63:0]              addr;
        logic [AMI_DATA_BITS-1:0] data;
        logic [AMI_SIZE_BITS-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                        valid;
        logic                        isWrite;
        logic [AMI_APP_BITS-1:0]     srcApp;
        logic [AMI_PORT_BITS-1:0]    srcPort;
        logic [AMI_CHANNEL_BITS-1:0] channel;
        logic [63:0]                 addr;
        logic [AMI_DATA_BITS-1:0]    data;
        logic [AMI_SIZE_BITS-1:0]    size;
    } AMIReq;

    typedef struct packed {
        logic        valid;
        logic        in_memory;
        logic        readable;
        logic        writable;
        logic [63:0] va_start;
        logic [63:0] va_end;
        logic [63:0] pa;
    } AMIAPP_TLB_Entry;
endpackage

// File: rtl/ami_tlb_match.sv
// ami_tlb_match: per-entry range compare with lowest-index priority select.
// denied flags a hit whose entry is not resident or lacks the needed permission.
module ami_tlb_match
    import AMITypes::*;
#(
    parameter int N = AMI_NUM_APP_TLB_ENTRIES,
    localparam int IW = $clog2(N)
) (
    input  AMIAPP_TLB_Entry entries [N],
    input  logic [63:0]     addr,
    input  logic            is_write,
    output logic            hit,
    output logic [IW-1:0]   idx,
    output logic [63:0]     offset,
    output logic            denied,
    output XLAT_CAUSE       cause
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (entries[i].valid && addr >= entries[i].va_start && addr < entries[i].va_end) begin
                hit = 1'b1;
                idx = IW'(i);
            end
    end

    assign offset = addr - entries[idx].va_start;
    assign denied = !entries[idx].in_memory ||
                    (is_write ? !entries[idx].writable : !entries[idx].readable);
    assign cause  = !hit ? XLAT_MISS : !entries[idx].in_memory ? XLAT_NOT_RESIDENT : XLAT_PERM;
endmodule

// File: rtl/ami_app_tlb_xlat.sv
// ami_app_tlb_xlat: per-app/port VA->PA translation ahead of ADDR_XLATED_Q.
// Passing requests emerge one cycle later; failing ones are dropped and logged.
module ami_app_tlb_xlat
    import AMITypes::*;
#(
    parameter logic [AMI_APP_BITS-1:0]  APP_ID            = '0,
    parameter logic [AMI_PORT_BITS-1:0] PORT_ID           = '0,
    parameter int                       NUM_ENTRIES       = AMI_NUM_APP_TLB_ENTRIES,
    parameter int                       CHAN_REGION_SHIFT = 34,
    parameter int                       INTERLEAVE_SHIFT  = 6,
    localparam int IW = $clog2(NUM_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  AMIRequest       req_in,
    output logic            req_grant,
    output AMIReq           xlat_out,
    input  logic            xlat_ready,
    input  logic            cfg_begin,
    input  logic            cfg_commit,
    input  logic            cfg_wr_valid,
    input  logic [IW-1:0]   cfg_wr_idx,
    input  AMIAPP_TLB_Entry cfg_wr_entry,
    output APP_TLB_STATE    tlb_state,
    output logic            fault_valid,
    output logic [63:0]     fault_addr,
    output logic            fault_is_write,
    output logic [1:0]      fault_cause,
    input  logic            fault_clear,
    output logic [15:0]     fault_count
);
    AMIAPP_TLB_Entry tlb [NUM_ENTRIES];
    APP_TLB_STATE    state_next;
    AMIReq           xlat_next;
    XLAT_CAUSE       cause;
    logic            hit, denied, fire, pass, fault;
    logic [IW-1:0]   idx;
    logic [63:0]     offset, pa;

    ami_tlb_match #(.N(NUM_ENTRIES)) u_match (
        .entries  (tlb),
        .addr     (req_in.addr),
        .is_write (req_in.isWrite),
        .hit      (hit),
        .idx      (idx),
        .offset   (offset),
        .denied   (denied),
        .cause    (cause)
    );

    assign pa        = tlb[idx].pa + offset;
    assign req_grant = tlb_state == APP_TLB_ENABLED && (!xlat_out.valid || xlat_ready);
    assign fire      = req_in.valid && req_grant;
    assign pass      = fire && hit && !denied;
    assign fault     = fire && !(hit && !denied);

    always_comb begin
        state_next = cfg_begin ? APP_TLB_PROGRAMMING :
                     (cfg_commit && tlb_state == APP_TLB_PROGRAMMING) ? APP_TLB_ENABLED : tlb_state;
    end

    always_comb begin
        xlat_next         = '0;
        xlat_next.valid   = 1'b1;
        xlat_next.isWrite = req_in.isWrite;
        xlat_next.srcApp  = APP_ID;
        xlat_next.srcPort = PORT_ID;
        xlat_next.channel = DISABLE_INTERLEAVE ? pa[CHAN_REGION_SHIFT +: AMI_CHANNEL_BITS]
                                               : pa[INTERLEAVE_SHIFT +: AMI_CHANNEL_BITS];
        xlat_next.addr    = pa;
        xlat_next.data    = req_in.data;
        xlat_next.size    = req_in.size;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlb_state <= APP_TLB_DISABLED;
            for (int i = 0; i < NUM_ENTRIES; i++) tlb[i] <= '0;
        end else begin
            tlb_state <= state_next;
            if (cfg_wr_valid && tlb_state == APP_TLB_PROGRAMMING) tlb[cfg_wr_idx] <= cfg_wr_entry;
        end
    end

    // Only valid drops on drain; the payload fields simply hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xlat_out <= '0;
        else if (pass) xlat_out <= xlat_next;
        else if (xlat_ready) xlat_out.valid <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid    <= 1'b0;
            fault_addr     <= '0;
            fault_is_write <= 1'b0;
            fault_cause    <= '0;
            fault_count    <= '0;
        end else begin
            if (fault) fault_count <= fault_count + {15'b0, fault_count != 16'hFFFF};
            if (fault && (!fault_valid || fault_clear)) begin
                fault_valid    <= 1'b1;
                fault_addr     <= req_in.addr;
                fault_is_write <= req_in.isWrite;
                fault_cause    <= cause;
            end else if (fault_clear) begin
                fault_valid    <= 1'b0;
                fault_addr     <= '0;
                fault_is_write <= 1'b0;
                fault_cause    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ami_app_tlb_xlat.sv
// tb_ami_app_tlb_xlat: directed scenarios plus randomized traffic scored against a TLB model.
module tb_ami_app_tlb_xlat;
    import AMITypes::*;

    localparam logic [AMI_APP_BITS-1:0]  APP = 4'h5;
    localparam logic [AMI_PORT_BITS-1:0] PRT = 2'h2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    AMIRequest       req_in;
    logic            req_grant;
    AMIReq           xlat_out;
    logic            xlat_ready;
    logic            cfg_begin, cfg_commit, cfg_wr_valid;
    logic [1:0]      cfg_wr_idx;
    AMIAPP_TLB_Entry cfg_wr_entry;
    APP_TLB_STATE    tlb_state;
    logic            fault_valid, fault_is_write, fault_clear;
    logic [63:0]     fault_addr;
    logic [1:0]      fault_cause;
    logic [15:0]     fault_count;

    int total = 0;
    int bad = 0;
    AMIAPP_TLB_Entry ref_tlb [4];
    logic [AMI_DATA_BITS-1:0] last_data;

    always #5 clk = ~clk;

    ami_app_tlb_xlat #(.APP_ID(APP), .PORT_ID(PRT)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_grant(req_grant),
        .xlat_out(xlat_out), .xlat_ready(xlat_ready), .cfg_begin(cfg_begin),
        .cfg_commit(cfg_commit), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_idx(cfg_wr_idx),
        .cfg_wr_entry(cfg_wr_entry), .tlb_state(tlb_state), .fault_valid(fault_valid),
        .fault_addr(fault_addr), .fault_is_write(fault_is_write), .fault_cause(fault_cause),
        .fault_clear(fault_clear), .fault_count(fault_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic AMIAPP_TLB_Entry ent(input logic [63:0] s, input logic [63:0] e,
                                            input logic [63:0] p, input logic im,
                                            input logic r, input logic w);
        AMIAPP_TLB_Entry x;
        x = '0;
        x.valid = 1'b1;
        x.in_memory = im;
        x.readable = r;
        x.writable = w;
        x.va_start = s;
        x.va_end = e;
        x.pa = p;
        return x;
    endfunction

    task automatic prog(input int i, input AMIAPP_TLB_Entry e);
        cfg_wr_valid = 1'b1;
        cfg_wr_idx = 2'(i);
        cfg_wr_entry = e;
        ref_tlb[i] = e;
        tick;
        cfg_wr_valid = 1'b0;
    endtask

    task automatic go_prog;
        cfg_begin = 1'b1;
        tick;
        cfg_begin = 1'b0;
    endtask

    task automatic go_enable;
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
    endtask

    task automatic set_req(input logic wr, input logic [63:0] a);
        req_in = '0;
        req_in.valid = 1'b1;
        req_in.isWrite = wr;
        req_in.addr = a;
        req_in.data = {$urandom, $urandom};
        req_in.size = 8'($urandom);
        last_data = req_in.data;
    endtask

    task automatic send(input logic wr, input logic [63:0] a);
        set_req(wr, a);
        tick;
        req_in.valid = 1'b0;
    endtask

    // Reference: first entry (lowest index) whose [start,end) holds the address decides.
    function automatic void lookup(input logic [63:0] a, input logic wr, output logic ok,
                                   output logic [1:0] cz, output logic [63:0] p);
        int s;
        s = -1;
        ok = 1'b0;
        cz = 2'd0;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (s < 0 && ref_tlb[i].valid && a >= ref_tlb[i].va_start && a < ref_tlb[i].va_end) s = i;
        if (s >= 0) begin
            if (!ref_tlb[s].in_memory) cz = 2'd2;
            else if (wr ? !ref_tlb[s].writable : !ref_tlb[s].readable) cz = 2'd1;
            else begin
                ok = 1'b1;
                p = ref_tlb[s].pa + (a - ref_tlb[s].va_start);
            end
        end
    endfunction

    initial begin
        logic        exp_v, exp_fv, exp_fw, g, ok;
        logic [1:0]  exp_fc, cz;
        logic [63:0] exp_fa, p, exp_pa;
        logic [AMI_DATA_BITS-1:0] exp_data;
        logic [AMI_SIZE_BITS-1:0] exp_size;
        logic        exp_wr;
        int          exp_cnt;

        req_in = '0;
        xlat_ready = 1'b1;
        cfg_begin = 1'b0;
        cfg_commit = 1'b0;
        cfg_wr_valid = 1'b0;
        cfg_wr_idx = '0;
        cfg_wr_entry = '0;
        fault_clear = 1'b0;
        for (int i = 0; i < 4; i++) ref_tlb[i] = '0;
        repeat (2) tick;
        chk("rst_state", 64'(tlb_state), 64'(APP_TLB_DISABLED));
        chk("rst_xlat_zero", 64'(|xlat_out), 64'd0);
        chk("rst_grant", 64'(req_grant), 64'd0);
        chk("rst_fault_valid", 64'(fault_valid), 64'd0);
        chk("rst_fault_count", 64'(fault_count), 64'd0);
        rst_n = 1'b1;
        tick;

        go_prog;
        chk("state_prog", 64'(tlb_state), 64'(APP_TLB_PROGRAMMING));
        prog(0, ent(64'h1000, 64'h2000, 64'h4_0000_0000, 1'b1, 1'b1, 1'b1));
        go_enable;
        chk("state_en", 64'(tlb_state), 64'(APP_TLB_ENABLED));
        chk("grant_en", 64'(req_grant), 64'd1);

        send(1'b0, 64'h1040);
        chk("pass_valid", 64'(xlat_out.valid), 64'd1);
        chk("pass_addr", xlat_out.addr, 64'h4_0000_0040);
        chk("pass_chan", 64'(xlat_out.channel), 64'd1);
        chk("pass_app", 64'(xlat_out.srcApp), 64'(APP));
        chk("pass_port", 64'(xlat_out.srcPort), 64'(PRT));
        chk("pass_data", 64'(xlat_out.data), 64'(last_data));
        tick;
        chk("drain_valid", 64'(xlat_out.valid), 64'd0);

        send(1'b0, 64'h2000);
        chk("end_excl_noout", 64'(xlat_out.valid), 64'd0);
        chk("end_excl_fv", 64'(fault_valid), 64'd1);
        chk("end_excl_fa", fault_addr, 64'h2000);
        chk("end_excl_cause", 64'(fault_cause), 64'd0);
        chk("end_excl_cnt", 64'(fault_count), 64'd1);
        fault_clear = 1'b1;
        tick;
        fault_clear = 1'b0;
        chk("clr_fv", 64'(fault_valid), 64'd0);
        chk("clr_cnt_kept", 64'(fault_count), 64'd1);

        go_prog;
        prog(0, ent(64'h1000, 64'h2000, 64'h4_0000_0000, 1'b1, 1'b1, 1'b0));
        go_enable;
        send(1'b1, 64'h1000);
        chk("perm_noout", 64'(xlat_out.valid), 64'd0);
        chk("perm_fa", fault_addr, 64'h1000);
        chk("perm_cause", 64'(fault_cause), 64'd1);
        chk("perm_wr", 64'(fault_is_write), 64'd1);
        chk("perm_cnt", 64'(fault_count), 64'd2);
        send(1'b0, 64'h3000);
        chk("sticky_fa", fault_addr, 64'h1000);
        chk("sticky_cause", 64'(fault_cause), 64'd1);
        chk("sticky_cnt", 64'(fault_count), 64'd3);
        fault_clear = 1'b1;
        tick;
        fault_clear = 1'b0;
        chk("clr2_fv", 64'(fault_valid), 64'd0);
        chk("clr2_fa", fault_addr, 64'd0);

        send(1'b0, 64'h3000);
        fault_clear = 1'b1;
        send(1'b0, 64'h5000);
        fault_clear = 1'b0;
        chk("clr_same_fv", 64'(fault_valid), 64'd1);
        chk("clr_same_fa", fault_addr, 64'h5000);
        chk("clr_same_cnt", 64'(fault_count), 64'd5);
        fault_clear = 1'b1;
        tick;
        fault_clear = 1'b0;

        go_prog;
        prog(0, ent(64'h1000, 64'h2000, 64'h4_0000_0000, 1'b1, 1'b1, 1'b1));
        go_enable;
        xlat_ready = 1'b0;
        set_req(1'b0, 64'h1100);
        tick;
        chk("bp_a_addr", xlat_out.addr, 64'h4_0000_0100);
        chk("bp_grant0", 64'(req_grant), 64'd0);
        set_req(1'b1, 64'h1200);
        tick;
        chk("bp_hold1", xlat_out.addr, 64'h4_0000_0100);
        tick;
        chk("bp_hold2", xlat_out.addr, 64'h4_0000_0100);
        chk("bp_hold_wr", 64'(xlat_out.isWrite), 64'd0);
        xlat_ready = 1'b1;
        #1;
        chk("bp_grant1", 64'(req_grant), 64'd1);
        tick;
        req_in.valid = 1'b0;
        chk("bp_b_addr", xlat_out.addr, 64'h4_0000_0200);
        chk("bp_b_wr", 64'(xlat_out.isWrite), 64'd1);
        tick;
        chk("bp_empty", 64'(xlat_out.valid), 64'd0);

        xlat_ready = 1'b0;
        send(1'b0, 64'h1300);
        go_prog;
        chk("drain_state", 64'(tlb_state), 64'(APP_TLB_PROGRAMMING));
        chk("drain_held", xlat_out.addr, 64'h4_0000_0300);
        chk("drain_held_v", 64'(xlat_out.valid), 64'd1);
        chk("drain_grant", 64'(req_grant), 64'd0);
        xlat_ready = 1'b1;
        set_req(1'b0, 64'h1040);
        tick;
        req_in.valid = 1'b0;
        chk("drain_done", 64'(xlat_out.valid), 64'd0);
        chk("prog_nogrant", 64'(req_grant), 64'd0);
        go_enable;
        chk("reenable", 64'(req_grant), 64'd1);
        cfg_wr_valid = 1'b1;
        cfg_wr_idx = 2'd0;
        cfg_wr_entry = '0;
        tick;
        cfg_wr_valid = 1'b0;
        send(1'b0, 64'h1040);
        chk("en_wr_ignored", xlat_out.addr, 64'h4_0000_0040);
        chk("en_wr_ignored_v", 64'(xlat_out.valid), 64'd1);

        cfg_begin = 1'b1;
        cfg_commit = 1'b1;
        tick;
        cfg_begin = 1'b0;
        cfg_commit = 1'b0;
        chk("begin_wins", 64'(tlb_state), 64'(APP_TLB_PROGRAMMING));
        prog(1, ent(64'h10000, 64'h20000, 64'h10_0000, 1'b1, 1'b1, 1'b1));
        prog(3, ent(64'h10000, 64'h30000, 64'h90_0000, 1'b1, 1'b1, 1'b1));
        prog(2, ent(64'h8000, 64'h9000, 64'h77_7000, 1'b0, 1'b1, 1'b1));
        go_enable;
        send(1'b0, 64'h10080);
        chk("ovl_low_idx", xlat_out.addr, 64'h10_0080);
        chk("ovl_chan", 64'(xlat_out.channel), 64'd0);
        send(1'b1, 64'h28000);
        chk("ovl_e3", xlat_out.addr, 64'h91_8000);
        send(1'b0, 64'h8000);
        chk("nres_noout", 64'(xlat_out.valid), 64'd0);
        chk("nres_cause", 64'(fault_cause), 64'd2);
        chk("nres_fa", fault_addr, 64'h8000);
        chk("nres_cnt", 64'(fault_count), 64'd6);
        fault_clear = 1'b1;
        tick;
        fault_clear = 1'b0;

        go_prog;
        for (int i = 0; i < 4; i++) begin
            logic [63:0] s;
            s = 64'($urandom_range(0, 32'h8000));
            prog(i, ent(s, s + 64'($urandom_range(1, 32'h3000)), {$urandom, $urandom},
                        $urandom_range(7) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0));
            ref_tlb[i].valid = $urandom_range(7) != 0;
            cfg_wr_entry = ref_tlb[i];
            cfg_wr_valid = 1'b1;
            tick;
            cfg_wr_valid = 1'b0;
        end
        go_enable;
        exp_v = 1'b0;
        exp_fv = 1'b0;
        exp_fa = '0;
        exp_fw = 1'b0;
        exp_fc = '0;
        exp_cnt = 6;
        exp_pa = '0;
        exp_data = '0;
        exp_size = '0;
        exp_wr = 1'b0;
        for (int k = 0; k < 300; k++) begin
            int j;
            j = $urandom_range(3);
            case ($urandom_range(3))
                0: set_req($urandom_range(1) != 0, ref_tlb[j].va_start);
                1: set_req($urandom_range(1) != 0, ref_tlb[j].va_end);
                2: set_req($urandom_range(1) != 0, ref_tlb[j].va_end - 64'd1);
                default: set_req($urandom_range(1) != 0, 64'($urandom_range(0, 32'hC000)));
            endcase
            req_in.valid = $urandom_range(3) != 0;
            xlat_ready = $urandom_range(3) != 0;
            fault_clear = $urandom_range(15) == 0;
            #1;
            g = !exp_v || xlat_ready;
            chk("rnd_grant", 64'(req_grant), 64'(g));
            lookup(req_in.addr, req_in.isWrite, ok, cz, p);
            if (req_in.valid && g && ok) begin
                exp_v = 1'b1;
                exp_pa = p;
                exp_data = req_in.data;
                exp_size = req_in.size;
                exp_wr = req_in.isWrite;
            end else if (xlat_ready) exp_v = 1'b0;
            if (req_in.valid && g && !ok) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (!exp_fv || fault_clear) begin
                    exp_fv = 1'b1;
                    exp_fa = req_in.addr;
                    exp_fw = req_in.isWrite;
                    exp_fc = cz;
                end
            end else if (fault_clear) begin
                exp_fv = 1'b0;
                exp_fa = '0;
                exp_fw = 1'b0;
                exp_fc = '0;
            end
            tick;
            chk("rnd_valid", 64'(xlat_out.valid), 64'(exp_v));
            if (exp_v) begin
                chk("rnd_addr", xlat_out.addr, exp_pa);
                chk("rnd_chan", 64'(xlat_out.channel), 64'(exp_pa[6]));
                chk("rnd_data", 64'(xlat_out.data), 64'(exp_data));
                chk("rnd_size", 64'(xlat_out.size), 64'(exp_size));
                chk("rnd_wr", 64'(xlat_out.isWrite), 64'(exp_wr));
            end
            chk("rnd_fv", 64'(fault_valid), 64'(exp_fv));
            chk("rnd_fa", fault_addr, exp_fa);
            chk("rnd_fw", 64'(fault_is_write), 64'(exp_fw));
            chk("rnd_fc", 64'(fault_cause), 64'(exp_fc));
            chk("rnd_cnt", 64'(fault_count), 64'(exp_cnt));
        end
        req_in.valid = 1'b0;
        fault_clear = 1'b0;
        xlat_ready = 1'b1;
        tick;

        go_prog;
        prog(0, ent(64'h1000, 64'h2000, 64'h4_0000_0000, 1'b1, 1'b1, 1'b1));
        go_enable;
        xlat_ready = 1'b0;
        send(1'b0, 64'h1040);
        chk("pre_rst_valid", 64'(xlat_out.valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(xlat_out.valid), 64'd0);
        chk("async_rst_state", 64'(tlb_state), 64'(APP_TLB_DISABLED));
        #2;
        rst_n = 1'b1;
        xlat_ready = 1'b1;
        tick;
        go_prog;
        go_enable;
        send(1'b0, 64'h1040);
        chk("post_rst_miss_v", 64'(xlat_out.valid), 64'd0);
        chk("post_rst_fv", 64'(fault_valid), 64'd1);
        chk("post_rst_cause", 64'(fault_cause), 64'd0);
        chk("post_rst_cnt", 64'(fault_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
